// File: rtl/rv_isa_pkg.sv
// ============================================================================
// Module : rv_isa_pkg
// Brief  : RV32 opcodes, loader op_class codes and loader FSM state type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv_isa_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] CLS_R      = 3'd0;
   localparam logic [2:0] CLS_I      = 3'd1;
   localparam logic [2:0] CLS_LOAD   = 3'd2;
   localparam logic [2:0] CLS_STORE  = 3'd3;
   localparam logic [2:0] CLS_BRANCH = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } load_state_t;

endpackage

`default_nettype wire

// File: rtl/rv_field_packer.sv
// ============================================================================
// Module : rv_field_packer
// Brief  : Combinational packing of instruction fields into an RV32 word.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rv_field_packer
   import rv_isa_pkg::*;
#(
   parameter logic [31:0] NOP_WORD = 32'h00000013
) (
   input  logic [2:0]  i_op_class,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [2:0]  i_funct3,
   input  logic        i_alt,
   input  logic [12:0] i_imm,
   output logic [31:0] o_word,
   output logic        o_illegal
);

   logic w_is_shift;

   assign w_is_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);

   always_comb begin
      o_word    = NOP_WORD;
      o_illegal = 1'b0;
      case (i_op_class)
         CLS_R:
            o_word = {1'b0, i_alt, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, OPC_R};
         CLS_I:
            // Shifts carry shamt in imm[4:0] and the arith/logic selector in bit 30
            if (w_is_shift)
               o_word = {1'b0, i_alt, 5'b0, i_imm[4:0], i_rs1, i_funct3, i_rd, OPC_I};
            else
               o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_I};
         CLS_LOAD:
            o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_LOAD};
         CLS_STORE:
            o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPC_STORE};
         CLS_BRANCH: begin
            o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                         i_imm[4:1], i_imm[11], OPC_BRANCH};
            o_illegal = i_imm[0];
         end
         default: begin
            o_word    = NOP_WORD;
            o_illegal = 1'b1;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/instr_encoder_loader.sv
// ============================================================================
// Module : instr_encoder_loader
// Brief  : Encodes instruction field bundles and streams them into imem.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_encoder_loader
   import rv_isa_pkg::*;
#(
   parameter int          ADDR_W   = 32,
   parameter int          CNT_W    = 8,
   parameter logic [31:0] NOP_WORD = 32'h00000013
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  count,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op_class,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        funct3,
   input  logic              alt,
   input  logic [12:0]       imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   load_state_t       r_state;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [CNT_W-1:0]  r_remaining;
   logic              r_imem_we;
   logic [ADDR_W-1:0] r_imem_addr;
   logic [31:0]       r_imem_wdata;
   logic              r_done;
   logic              r_err;

   logic [31:0]       w_word;
   logic              w_illegal;
   logic              w_accept;

   rv_field_packer #(
      .NOP_WORD (NOP_WORD)
   ) u_packer (
      .i_op_class (op_class),
      .i_rd       (rd),
      .i_rs1      (rs1),
      .i_rs2      (rs2),
      .i_funct3   (funct3),
      .i_alt      (alt),
      .i_imm      (imm),
      .o_word     (w_word),
      .o_illegal  (w_illegal)
   );

   // abort masks ready so no word is consumed in the cancel cycle
   assign in_ready = (r_state == ST_LOAD) && !abort;
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cur_addr   <= '0;
         r_remaining  <= '0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_imem_we <= 1'b0;
         r_done    <= 1'b0;
         if (abort) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE, ST_DONE: begin
                  if (start) begin
                     r_cur_addr  <= base_addr & ~ADDR_W'(3);
                     r_remaining <= count;
                     r_err       <= 1'b0;
                     if (count == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= ST_LOAD;
                     end
                  end
               end
               ST_LOAD: begin
                  if (w_accept) begin
                     r_imem_we    <= 1'b1;
                     r_imem_addr  <= r_cur_addr;
                     r_imem_wdata <= w_word;
                     r_cur_addr   <= r_cur_addr + ADDR_W'(4);
                     r_remaining  <= r_remaining - CNT_W'(1);
                     if (w_illegal)
                        r_err <= 1'b1;
                     if (r_remaining == CNT_W'(1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign imem_we    = r_imem_we;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign busy       = (r_state == ST_LOAD);
   assign done       = r_done;
   assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
// Module : tb_instr_encoder_loader
// Brief  : Scoreboarded random and directed bench for instr_encoder_loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        reset, start, abort, in_valid, alt;
   logic [31:0] base_addr;
   logic [7:0]  count;
   logic [2:0]  op_class, funct3;
   logic [4:0]  rd, rs1, rs2;
   logic [12:0] imm;
   logic        in_ready, imem_we, busy, done, err;
   logic [31:0] imem_addr, imem_wdata;

   instr_encoder_loader dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .count      (count),
      .abort      (abort),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op_class   (op_class),
      .rd         (rd),
      .rs1        (rs1),
      .rs2        (rs2),
      .funct3     (funct3),
      .alt        (alt),
      .imm        (imm),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic        done;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_addr;
   int          m_left;
   bit          m_err;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Reference encoder built from field positions with plain arithmetic
   function automatic int unsigned model_word(int unsigned cls, int unsigned f_rd,
         int unsigned f_rs1, int unsigned f_rs2, int unsigned f3, int unsigned f_alt,
         int unsigned f_imm, output bit bad);
      int unsigned regs;
      bad  = 0;
      regs = f_rs1 * (1 << 15) + f3 * (1 << 12);
      case (cls)
         0: return 51 + f_rd * 128 + regs + f_rs2 * (1 << 20) + f_alt * (1 << 30);
         1: if (f3 == 1 || f3 == 5)
               return 19 + f_rd * 128 + regs + (f_imm % 32) * (1 << 20) + f_alt * (1 << 30);
            else
               return 19 + f_rd * 128 + regs + (f_imm % 4096) * (1 << 20);
         2: return 3 + f_rd * 128 + regs + (f_imm % 4096) * (1 << 20);
         3: return 35 + (f_imm % 32) * 128 + regs + f_rs2 * (1 << 20)
                   + ((f_imm / 32) % 128) * (1 << 25);
         4: begin
            bad = (f_imm % 2) == 1;
            return 99 + ((f_imm / 2048) % 2) * 128 + ((f_imm / 2) % 16) * 256 + regs
                   + f_rs2 * (1 << 20) + ((f_imm / 32) % 64) * (1 << 25)
                   + ((f_imm / 4096) % 2) * (1 << 31);
         end
         default: begin
            bad = 1;
            return 32'h00000013;
         end
      endcase
   endfunction

   // Monitor: every write strobe or done pulse must match the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (imem_we || done) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: we=%b done=%b addr=%h data=%h, required no output",
                     imem_we, done, imem_addr, imem_wdata);
         end else begin
            e = sbq.pop_front();
            check("imem_we", {31'b0, imem_we}, {31'b0, e.we});
            if (e.we) begin
               check("imem_addr", imem_addr, e.addr);
               check("imem_wdata", imem_wdata, e.data);
            end
            check("done", {31'b0, done}, {31'b0, e.done});
         end
      end
   end

   task automatic do_start(logic [31:0] b, logic [7:0] c);
      @(negedge clk);
      start     = 1'b1;
      base_addr = b;
      count     = c;
      m_addr    = b & 32'hFFFF_FFFC;
      m_left    = c;
      m_err     = 0;
      if (c == 0)
         sbq.push_back('{we: 1'b0, addr: 32'h0, data: 32'h0, done: 1'b1});
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic do_word(logic [2:0] cls, logic [4:0] f_rd, logic [4:0] f_rs1,
         logic [4:0] f_rs2, logic [2:0] f3, logic f_alt, logic [12:0] f_imm,
         logic [31:0] expw, bit bad, bit force_valid, output int waited);
      bit acc = 0;
      waited = 0;
      while (!acc) begin
         @(negedge clk);
         op_class  = cls;  rd = f_rd; rs1 = f_rs1; rs2 = f_rs2;
         funct3    = f3;   alt = f_alt; imm = f_imm;
         in_valid  = force_valid || ($urandom_range(0, 3) != 0);
         start     = ($urandom_range(0, 4) == 0);
         base_addr = $urandom;
         count     = 8'($urandom);
         #1;
         if (in_valid && in_ready) begin
            acc = 1;
            sbq.push_back('{we: 1'b1, addr: m_addr, data: expw, done: (m_left == 1)});
            m_addr = m_addr + 32'd4;
            m_left--;
            if (bad) m_err = 1;
         end
         @(posedge clk);
         #1 in_valid = 1'b0;
         start = 1'b0;
         if (!acc) begin
            waited++;
            if (waited > 20) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
               return;
            end
         end
      end
   endtask

   task automatic rand_word(bit force_valid);
      int unsigned cls, w;
      logic [4:0]  r_d, r_s1, r_s2;
      logic [2:0]  f3;
      logic        a;
      logic [12:0] im;
      bit          bad;
      int          wt;
      cls  = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      r_d  = 5'($urandom); r_s1 = 5'($urandom); r_s2 = 5'($urandom);
      f3   = 3'($urandom); a = 1'($urandom); im = 13'($urandom);
      w    = model_word(cls, r_d, r_s1, r_s2, f3, a, im, bad);
      do_word(3'(cls), r_d, r_s1, r_s2, f3, a, im, w, bad, force_valid, wt);
   endtask

   initial begin
      int wt;
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int wt;
      reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      base_addr = '0; count = '0; op_class = '0; funct3 = '0;
      rd = '0; rs1 = '0; rs2 = '0; alt = 1'b0; imm = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_imem_we", {31'b0, imem_we}, 32'd0);
      check("rst_imem_addr", imem_addr, 32'd0);
      check("rst_imem_wdata", imem_wdata, 32'd0);
      check("rst_flags", {27'b0, busy, done, err, in_ready, 1'b0}, 32'd0);
      #1 reset = 1'b0;

      // add x5,x6,x7 and sub x5,x6,x7
      do_start(32'h0000_0040, 8'd2);
      do_word(3'd0, 5'd5, 5'd6, 5'd7, 3'd0, 1'b0, 13'd0, 32'h007302B3, 0, 1, wt);
      do_word(3'd0, 5'd5, 5'd6, 5'd7, 3'd0, 1'b1, 13'd0, 32'h407302B3, 0, 1, wt);

      // addi / sw / beq back-to-back
      do_start(32'h0000_0100, 8'd3);
      do_word(3'd1, 5'd13, 5'd0, 5'd0, 3'd0, 1'b0, 13'd8, 32'h00800693, 0, 1, wt);
      check("no_bubble_0", wt, 0);
      do_word(3'd3, 5'd0, 5'd6, 5'd7, 3'd2, 1'b0, 13'd12, 32'h00732623, 0, 1, wt);
      check("no_bubble_1", wt, 0);
      do_word(3'd4, 5'd0, 5'd6, 5'd7, 3'd0, 1'b0, 13'd8, 32'h00730463, 0, 1, wt);
      check("no_bubble_2", wt, 0);

      // zero-length load
      do_start(32'h0000_0200, 8'd0);
      @(negedge clk);
      check("cnt0_busy", {31'b0, busy}, 32'd0);

      // illegal class then legal word; err sticky until next start
      do_start(32'h0000_0300, 8'd2);
      do_word(3'd6, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 13'd0, 32'h00000013, 1, 1, wt);
      do_word(3'd0, 5'd5, 5'd6, 5'd7, 3'd0, 1'b0, 13'd0, 32'h007302B3, 0, 1, wt);
      @(negedge clk);
      check("err_sticky", {31'b0, err}, 32'd1);
      do_start(32'h0000_0380, 8'd1);
      check("err_cleared", {31'b0, err}, 32'd0);
      do_word(3'd2, 5'd9, 5'd10, 5'd0, 3'd2, 1'b0, 13'h0FF0, 32'hFF052483, 0, 1, wt);

      // abort after two accepts, then restart elsewhere
      do_start(32'h0000_0400, 8'd4);
      rand_word(1);
      rand_word(1);
      @(negedge clk);
      abort = 1'b1; in_valid = 1'b1;
      #1 check("abort_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1 abort = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("abort_idle", {30'b0, busy, in_ready}, 32'd0);
      do_start(32'h0000_0503, 8'd1);
      rand_word(0);

      // address wrap
      do_start(32'hFFFF_FFFC, 8'd2);
      rand_word(0);
      rand_word(0);

      // randomized loads with err tracked by the model
      for (int t = 0; t < 12; t++) begin
         int n;
         n = (t % 5 == 4) ? 0 : $urandom_range(1, 8);
         do_start($urandom, 8'(n));
         for (int k = 0; k < n; k++)
            rand_word(t[0]);
         @(negedge clk);
         @(negedge clk);
         check("rand_err", {31'b0, err}, {31'b0, m_err});
         check("rand_busy", {31'b0, busy}, 32'd0);
      end

      // reset mid-load clears err and returns to idle
      do_start(32'h0000_0600, 8'd3);
      do_word(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0, 32'h00000013, 1, 1, wt);
      @(negedge clk);
      check("pre_reset_err", {31'b0, err}, 32'd1);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("post_reset", {29'b0, err, busy, in_ready}, 32'd0);

      repeat (3) @(negedge clk);
      check("sb_empty", sbq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
